// File: rtl/tile_map_arbiter_if.sv
// Bundle of requester and RAM-side signals for the tile-map arbiter.
// The slave modport is the arbiter; the master modport is its environment (requesters plus RAM).
interface tile_map_arbiter_if;
  logic        vid_req;
  logic [8:0]  vid_addr;
  logic        vid_gnt;
  logic        vid_rvalid;
  logic [1:0]  p_req;
  logic [1:0]  p_we;
  logic [17:0] p_addr;
  logic [5:0]  p_wdata;
  logic [1:0]  p_gnt;
  logic [1:0]  p_rvalid;
  logic [2:0]  rdata;
  logic [8:0]  ram_addr;
  logic        ram_we;
  logic [2:0]  ram_wdata;
  logic [2:0]  ram_rdata;

  modport slave (
    input  vid_req, vid_addr, p_req, p_we, p_addr, p_wdata, ram_rdata,
    output vid_gnt, vid_rvalid, p_gnt, p_rvalid, rdata, ram_addr, ram_we, ram_wdata
  );

  modport master (
    output vid_req, vid_addr, p_req, p_we, p_addr, p_wdata, ram_rdata,
    input  vid_gnt, vid_rvalid, p_gnt, p_rvalid, rdata, ram_addr, ram_we, ram_wdata
  );
endinterface

// File: rtl/tile_map_arbiter.sv
// Arbitrates one single-port tile-map RAM between video and two players (starvation-aware round-robin).
// Optional macro BORDER_PROTECT_EN: suppresses RAM writes that target border tiles of the play field.
module tile_map_arbiter #(
  parameter int TILES        = 300,
  parameter int COLS         = 20,
  parameter int ROWS         = 15,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              Clk,
  input  logic              Reset_n,
  tile_map_arbiter_if.slave bus
);

  localparam int             CW      = $clog2(STARVE_LIMIT + 1);
  localparam int             FIELD   = (TILES < ROWS * COLS) ? TILES : ROWS * COLS;
  localparam logic [8:0]     FIELD_A = 9'(FIELD);
  localparam logic [CW-1:0]  LIMIT   = CW'(STARVE_LIMIT);

  typedef enum logic { PL_P1 = 1'b0, PL_P2 = 1'b1 } player_e;
  typedef enum logic [1:0] { SRC_NONE, SRC_VID, SRC_P1, SRC_P2 } src_e;

  player_e                rr_ptr;
  logic [1:0][CW-1:0]     starve_cnt;
  logic [1:0]             starved;
  src_e                   grant;
  logic [8:0]             sel_addr;
  logic                   sel_we;
  logic [2:0]             sel_wdata;
  logic                   oor;
  logic                   write_ok;
  logic                   vid_rv_q;
  logic [1:0]             p_rv_q;
  logic                   oor_q;

  function automatic src_e pick_player(input logic [1:0] req, input player_e rr);
    if (req == 2'b11) return (rr == PL_P1) ? SRC_P1 : SRC_P2;
    else if (req[0])  return SRC_P1;
    else if (req[1])  return SRC_P2;
    else              return SRC_NONE;
  endfunction

  assign starved[0] = bus.p_req[0] && (starve_cnt[0] == LIMIT);
  assign starved[1] = bus.p_req[1] && (starve_cnt[1] == LIMIT);

  // Starved players first, then video, then players in round-robin order.
  always_comb begin
    grant = SRC_NONE;
    if (!Reset_n)          grant = SRC_NONE;
    else if (|starved)     grant = pick_player(starved, rr_ptr);
    else if (bus.vid_req)  grant = SRC_VID;
    else                   grant = pick_player(bus.p_req, rr_ptr);
  end

  always_comb begin
    sel_addr  = '0;
    sel_we    = 1'b0;
    sel_wdata = '0;
    case (grant)
      SRC_VID: sel_addr = bus.vid_addr;
      SRC_P1: begin
        sel_addr  = bus.p_addr[8:0];
        sel_we    = bus.p_we[0];
        sel_wdata = bus.p_wdata[2:0];
      end
      SRC_P2: begin
        sel_addr  = bus.p_addr[17:9];
        sel_we    = bus.p_we[1];
        sel_wdata = bus.p_wdata[5:3];
      end
      default: ;
    endcase
  end

  assign oor = (sel_addr >= FIELD_A);

`ifdef BORDER_PROTECT_EN
  localparam logic [8:0] COLS_A   = 9'(COLS);
  localparam logic [8:0] LAST_ROW = 9'(TILES - COLS);
  logic [8:0] col;
  logic       is_border;
  assign col       = sel_addr % COLS_A;
  assign is_border = (sel_addr < COLS_A) || (sel_addr >= LAST_ROW) ||
                     (col == 9'd0) || (col == COLS_A - 9'd1);
  assign write_ok  = sel_we && !oor && !is_border;
`else
  assign write_ok  = sel_we && !oor;
`endif

  assign bus.vid_gnt   = (grant == SRC_VID);
  assign bus.p_gnt     = {grant == SRC_P2, grant == SRC_P1};
  assign bus.ram_addr  = oor ? 9'd0 : sel_addr;
  assign bus.ram_we    = write_ok;
  assign bus.ram_wdata = sel_wdata;

  // Read tags travel one cycle alongside the RAM latency; out-of-field reads report a wall.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      vid_rv_q   <= 1'b0;
      p_rv_q     <= 2'b00;
      oor_q      <= 1'b0;
      rr_ptr     <= PL_P1;
      starve_cnt <= '0;
    end else begin
      vid_rv_q <= bus.vid_gnt;
      p_rv_q   <= bus.p_gnt & ~bus.p_we;
      oor_q    <= oor;
      if (bus.p_gnt[0])      rr_ptr <= PL_P2;
      else if (bus.p_gnt[1]) rr_ptr <= PL_P1;
      for (int i = 0; i < 2; i++) begin
        if (!bus.p_req[i] || bus.p_gnt[i]) starve_cnt[i] <= '0;
        else if (starve_cnt[i] != LIMIT)   starve_cnt[i] <= starve_cnt[i] + CW'(1);
      end
    end
  end

  assign bus.vid_rvalid = vid_rv_q;
  assign bus.p_rvalid   = p_rv_q;
  assign bus.rdata      = (vid_rv_q || (|p_rv_q)) ? (oor_q ? 3'd1 : bus.ram_rdata) : 3'd0;

endmodule

// File: tb/tb_tile_map_arbiter.sv
// Directed bench for tile_map_arbiter: grants checked inline, read responses via a scoreboard queue.
// Honours BORDER_PROTECT_EN when the design is built with it.
module tb_tile_map_arbiter;

  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  always #5 Clk = ~Clk;

  tile_map_arbiter_if bus();

  tile_map_arbiter dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  // Synchronous RAM model; contents reload while reset is held.
  logic [2:0] mem [0:511];

  function automatic logic [2:0] preset(input int a);
    case (a)
      29:      return 3'd4;
      41:      return 3'd2;
      50:      return 3'd2;
      60:      return 3'd3;
      100:     return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

  always @(posedge Clk) begin
    if (!Reset_n) begin
      for (int i = 0; i < 512; i++) mem[i] <= preset(i);
    end else if (bus.ram_we) begin
      mem[bus.ram_addr] <= bus.ram_wdata;
    end
    bus.ram_rdata <= mem[bus.ram_addr];
  end

  typedef struct {
    logic [2:0] src;
    logic [2:0] data;
    int         due;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  localparam logic [2:0] S_VID = 3'b001;
  localparam logic [2:0] S_P1  = 3'b010;
  localparam logic [2:0] S_P2  = 3'b100;

  always @(posedge Clk) cyc++;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic expectRead(input logic [2:0] src, input logic [2:0] data);
    exp_t e;
    e.src  = src;
    e.data = data;
    e.due  = cyc + 1;
    sb.push_back(e);
  endtask

  task automatic applyStimulus(input logic vreq, input logic [8:0] vaddr, input logic [1:0] preq,
                               input logic [1:0] pwe, input logic [8:0] a1, input logic [8:0] a2,
                               input logic [2:0] w1, input logic [2:0] w2);
    @(posedge Clk);
    #1;
    bus.vid_req  = vreq;
    bus.vid_addr = vaddr;
    bus.p_req    = preq;
    bus.p_we     = pwe;
    bus.p_addr   = {a2, a1};
    bus.p_wdata  = {w2, w1};
    @(negedge Clk);
  endtask

  task automatic checkGrant(input string name, input logic vg, input logic [1:0] pg,
                            input logic we, input logic [8:0] addr);
    checkOutput({name, "_gnt"}, {bus.p_gnt, bus.vid_gnt}, {pg, vg});
    checkOutput({name, "_we"}, bus.ram_we, we);
    if (vg || (|pg)) checkOutput({name, "_addr"}, bus.ram_addr, addr);
  endtask

  // Monitor: every rvalid pops the oldest expectation; overdue entries are reported as missing.
  always @(negedge Clk) begin
    exp_t       e;
    logic [2:0] rv;
    rv = {bus.p_rvalid, bus.vid_rvalid};
    if (rv != 3'b000) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_rvalid", rv, 0);
      end else begin
        e = sb.pop_front();
        checkOutput("rvalid_src", rv, e.src);
        checkOutput("rdata", bus.rdata, e.data);
        checkOutput("rvalid_cycle", cyc, e.due);
      end
    end else if (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      checkOutput("missing_rvalid", 0, e.src);
    end
  end

  initial begin
    bus.vid_req  = 1'b1;
    bus.vid_addr = 9'd29;
    bus.p_req    = 2'b11;
    bus.p_we     = 2'b11;
    bus.p_addr   = {9'd60, 9'd50};
    bus.p_wdata  = 6'b011_010;

    // Reset held with every request asserted.
    repeat (2) begin
      @(negedge Clk);
      checkOutput("reset_gnt", {bus.p_gnt, bus.vid_gnt}, 0);
      checkOutput("reset_we", bus.ram_we, 0);
      checkOutput("reset_rvalid", {bus.p_rvalid, bus.vid_rvalid}, 0);
    end

    @(posedge Clk);
    #1;
    Reset_n     = 1'b1;
    bus.vid_req = 1'b0;
    bus.p_we    = 2'b00;
    @(negedge Clk);
    checkGrant("rr_after_reset", 1'b0, 2'b01, 1'b0, 9'd50);
    checkOutput("no_rvalid_after_reset", {bus.p_rvalid, bus.vid_rvalid}, 0);
    expectRead(S_P1, 3'd2);

    // Both players continuously requesting: grants alternate.
    for (int i = 1; i <= 3; i++) begin
      applyStimulus(1'b0, 9'd0, 2'b11, 2'b00, 9'd50, 9'd60, 3'd0, 3'd0);
      if (i % 2 == 1) begin
        checkGrant("alternate_p2", 1'b0, 2'b10, 1'b0, 9'd60);
        expectRead(S_P2, 3'd3);
      end else begin
        checkGrant("alternate_p1", 1'b0, 2'b01, 1'b0, 9'd50);
        expectRead(S_P1, 3'd2);
      end
    end

    applyStimulus(1'b1, 9'd29, 2'b00, 2'b00, 9'd0, 9'd0, 3'd0, 3'd0);
    checkGrant("vid_read29", 1'b1, 2'b00, 1'b0, 9'd29);
    expectRead(S_VID, 3'd4);

    // Write-then-read ordering on tile 41.
    applyStimulus(1'b0, 9'd0, 2'b10, 2'b00, 9'd0, 9'd41, 3'd0, 3'd0);
    checkGrant("p2_read41_before", 1'b0, 2'b10, 1'b0, 9'd41);
    expectRead(S_P2, 3'd2);
    applyStimulus(1'b0, 9'd0, 2'b01, 2'b01, 9'd41, 9'd0, 3'd0, 3'd0);
    checkGrant("p1_write41", 1'b0, 2'b01, 1'b1, 9'd41);
    checkOutput("p1_write41_data", bus.ram_wdata, 0);
    applyStimulus(1'b0, 9'd0, 2'b10, 2'b00, 9'd0, 9'd41, 3'd0, 3'd0);
    checkGrant("p2_read41_after", 1'b0, 2'b10, 1'b0, 9'd41);
    expectRead(S_P2, 3'd0);

    // Video hogging: P2 breaks through after 8 denied cycles.
    for (int i = 1; i <= 20; i++) begin
      applyStimulus(1'b1, 9'd100, 2'b10, 2'b00, 9'd0, 9'd60, 3'd0, 3'd0);
      if (i == 9 || i == 18) begin
        checkGrant("starve_p2", 1'b0, 2'b10, 1'b0, 9'd60);
        expectRead(S_P2, 3'd3);
      end else begin
        checkGrant("starve_vid", 1'b1, 2'b00, 1'b0, 9'd100);
        expectRead(S_VID, 3'd4);
      end
    end

    applyStimulus(1'b0, 9'd0, 2'b00, 2'b00, 9'd0, 9'd0, 3'd0, 3'd0);
    checkGrant("idle", 1'b0, 2'b00, 1'b0, 9'd0);

    // Out-of-field accesses.
    applyStimulus(1'b0, 9'd0, 2'b01, 2'b01, 9'd305, 9'd0, 3'd2, 3'd0);
    checkGrant("oor_write", 1'b0, 2'b01, 1'b0, 9'd0);
    applyStimulus(1'b0, 9'd0, 2'b01, 2'b00, 9'd305, 9'd0, 3'd0, 3'd0);
    checkGrant("oor_read", 1'b0, 2'b01, 1'b0, 9'd0);
    expectRead(S_P1, 3'd1);

    // Tile 20 sits on the left border.
    applyStimulus(1'b0, 9'd0, 2'b01, 2'b01, 9'd20, 9'd0, 3'd2, 3'd0);
`ifdef BORDER_PROTECT_EN
    checkGrant("border_write", 1'b0, 2'b01, 1'b0, 9'd20);
`else
    checkGrant("border_write", 1'b0, 2'b01, 1'b1, 9'd20);
`endif
    applyStimulus(1'b0, 9'd0, 2'b01, 2'b00, 9'd20, 9'd0, 3'd0, 3'd0);
    checkGrant("border_read", 1'b0, 2'b01, 1'b0, 9'd20);
`ifdef BORDER_PROTECT_EN
    expectRead(S_P1, 3'd0);
`else
    expectRead(S_P1, 3'd2);
`endif

    // Same-address writes: rr_ptr points at P2, so P1 is served second and its data sticks.
    applyStimulus(1'b0, 9'd0, 2'b11, 2'b11, 9'd42, 9'd42, 3'd2, 3'd3);
    checkGrant("same_addr_first", 1'b0, 2'b10, 1'b1, 9'd42);
    checkOutput("same_addr_first_data", bus.ram_wdata, 3);
    applyStimulus(1'b0, 9'd0, 2'b01, 2'b01, 9'd42, 9'd0, 3'd2, 3'd0);
    checkGrant("same_addr_second", 1'b0, 2'b01, 1'b1, 9'd42);
    checkOutput("same_addr_second_data", bus.ram_wdata, 2);
    applyStimulus(1'b0, 9'd0, 2'b10, 2'b00, 9'd0, 9'd42, 3'd0, 3'd0);
    checkGrant("same_addr_read", 1'b0, 2'b10, 1'b0, 9'd42);
    expectRead(S_P2, 3'd2);

    repeat (3) begin
      applyStimulus(1'b0, 9'd0, 2'b00, 2'b00, 9'd0, 9'd0, 3'd0, 3'd0);
      checkGrant("drain", 1'b0, 2'b00, 1'b0, 9'd0);
    end
    checkOutput("scoreboard_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
